// File: rtl/regfile_pkg.sv
// Shared defaults, index helper and constants for the multi-port register file.
package regfile_pkg;

    localparam int WIDTH_DEF    = 32;
    localparam int DEPTH_DEF    = 32;
    localparam int NUM_READ_DEF = 2;

    // Address width for a given depth; a depth of 1 would give 0, so floor at 1.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int AW_DEF = addr_w(DEPTH_DEF);

    typedef logic [AW_DEF-1:0] reg_idx_t;

    localparam int       ZERO_REG     = 0;
    localparam reg_idx_t ZERO_REG_IDX = reg_idx_t'(ZERO_REG);

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by decode reservations,
// cleared by writeback or flush; exposes per-read-port pending lookups and busy_any.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int NUM_READ = NUM_READ_DEF,
    parameter int AW       = addr_w(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_resv_valid,
    input  logic [AW-1:0]          i_resv_addr,
    input  logic                   i_clr_valid,
    input  logic [AW-1:0]          i_clr_addr,
    input  logic                   i_flush,
    input  logic [NUM_READ*AW-1:0] i_lookup_addr,
    output logic [NUM_READ-1:0]    o_pending,
    output logic                   o_busy_any
);

    logic [DEPTH-1:0] r_pending;
    logic [DEPTH-1:0] w_pending_nxt;

    // Clear first so a same-cycle reservation of the written register wins;
    // flush then overrides any reservation.
    always_comb begin
        w_pending_nxt = r_pending;
        if (i_clr_valid && (i_clr_addr != AW'(ZERO_REG)))
            w_pending_nxt[i_clr_addr] = 1'b0;
        if (i_flush)
            w_pending_nxt = '0;
        else if (i_resv_valid && (i_resv_addr != AW'(ZERO_REG)))
            w_pending_nxt[i_resv_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_pending <= '0;
        else
            r_pending <= w_pending_nxt;
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_lookup
        assign o_pending[p] = r_pending[i_lookup_addr[p*AW +: AW]];
    end

    assign o_busy_any = |r_pending;

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-read-port register file with pending-write scoreboard.
// Optional same-cycle write-to-read bypass when REGFILE_BYPASS_EN is defined.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int NUM_READ = NUM_READ_DEF,
    localparam int AW      = addr_w(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_READ*AW-1:0]    rs_addr,
    output logic [NUM_READ*WIDTH-1:0] rs_data,
    output logic [NUM_READ-1:0]       rs_ready,
    input  logic [AW-1:0]             rd_addr,
    input  logic [WIDTH-1:0]          write_data,
    input  logic                      regWrite,
    input  logic                      resv_valid,
    input  logic [AW-1:0]             resv_addr,
    input  logic                      flush,
    output logic                      busy_any
);

    logic [WIDTH-1:0]    r_regs [DEPTH];
    logic                w_wr_en;
    logic [NUM_READ-1:0] w_pending;

    assign w_wr_en = regWrite && (rd_addr != AW'(ZERO_REG));

    // Register 0 is never written, so reset alone keeps it at zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_regs[i] <= '0;
        end else if (w_wr_en) begin
            r_regs[rd_addr] <= write_data;
        end
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .NUM_READ (NUM_READ),
        .AW       (AW)
    ) u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .i_resv_valid  (resv_valid),
        .i_resv_addr   (resv_addr),
        .i_clr_valid   (w_wr_en),
        .i_clr_addr    (rd_addr),
        .i_flush       (flush),
        .i_lookup_addr (rs_addr),
        .o_pending     (w_pending),
        .o_busy_any    (busy_any)
    );

    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
        logic [AW-1:0] w_addr;
        logic          w_zero;
        assign w_addr = rs_addr[p*AW +: AW];
        assign w_zero = (w_addr == AW'(ZERO_REG));
`ifdef REGFILE_BYPASS_EN
        // Writeback to the same register completes the hazard this cycle.
        logic w_byp;
        assign w_byp = w_wr_en && (rd_addr == w_addr);
        assign rs_data[p*WIDTH +: WIDTH] = w_zero ? '0 :
                                           w_byp  ? write_data : r_regs[w_addr];
        assign rs_ready[p] = w_zero | w_byp | ~w_pending[p];
`else
        assign rs_data[p*WIDTH +: WIDTH] = w_zero ? '0 : r_regs[w_addr];
        assign rs_ready[p] = w_zero | ~w_pending[p];
`endif
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp (4 read ports); expected port values are
// queued when a step is driven and drained/compared once outputs settle.
module tb_register_file_mp;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int NR = 4;
    localparam int AW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*AW-1:0]  rs_addr;
    logic [NR*W-1:0]   rs_data;
    logic [NR-1:0]     rs_ready;
    logic [AW-1:0]     rd_addr;
    logic [W-1:0]      write_data;
    logic              regWrite;
    logic              resv_valid;
    logic [AW-1:0]     resv_addr;
    logic              flush;
    logic              busy_any;

    int checks = 0;
    int errors = 0;
    string step;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        ready;
    } exp_t;
    exp_t q[$];

    register_file_mp #(.WIDTH(W), .DEPTH(D), .NUM_READ(NR)) dut (
        .clk        (clk),
        .rst        (rst),
        .rs_addr    (rs_addr),
        .rs_data    (rs_data),
        .rs_ready   (rs_ready),
        .rd_addr    (rd_addr),
        .write_data (write_data),
        .regWrite   (regWrite),
        .resv_valid (resv_valid),
        .resv_addr  (resv_addr),
        .flush      (flush),
        .busy_any   (busy_any)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int p, input int a);
        logic [AW-1:0] av;
        av = a[AW-1:0];
        rs_addr[p*AW +: AW] = av;
    endtask

    task automatic expect_port(input int p, input logic [31:0] d, input logic r);
        exp_t e;
        e.port = p; e.data = d; e.ready = r;
        q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [31:0] od;
        logic        orr;
        #2;
        while (q.size() > 0) begin
            e   = q.pop_front();
            od  = rs_data[e.port*W +: W];
            orr = rs_ready[e.port];
            checks++;
            assert (od === e.data) else begin
                errors++;
                $error("FAIL %s port%0d data: observed %h expected %h", step, e.port, od, e.data);
            end
            checks++;
            assert (orr === e.ready) else begin
                errors++;
                $error("FAIL %s port%0d ready: observed %b expected %b", step, e.port, orr, e.ready);
            end
        end
    endtask

    task automatic chk_busy(input logic exp);
        checks++;
        assert (busy_any === exp) else begin
            errors++;
            $error("FAIL %s busy_any: observed %b expected %b", step, busy_any, exp);
        end
    endtask

    task automatic idle();
        regWrite = 1'b0; resv_valid = 1'b0; flush = 1'b0;
        rd_addr = '0; resv_addr = '0; write_data = '0;
    endtask

    initial begin
        rst = 1'b0; rs_addr = '0;
        idle();
        // Reset with a write and reservation driven: both must be ignored.
        regWrite = 1'b1; rd_addr = 5'd9; write_data = 32'h1234;
        resv_valid = 1'b1; resv_addr = 5'd9;
        tick(); tick();
        idle();
        rst = 1'b1;
        step = "reset";
        for (int p = 0; p < NR; p++) begin
            set_rd(p, 9 + p);
            expect_port(p, 32'h0, 1'b1);
        end
        drain();
        chk_busy(1'b0);

        // Fill regs 1..31 with 10*i.
        for (int i = 1; i < D; i++) begin
            regWrite = 1'b1; rd_addr = i[AW-1:0]; write_data = 32'(10 * i);
            tick();
        end
        idle();
        step = "fill_read";
        for (int i = 0; i < D; i++) begin
            set_rd(0, i); set_rd(1, 31 - i); set_rd(2, i); set_rd(3, 0);
            expect_port(0, 32'(10 * i), 1'b1);
            expect_port(1, 32'(10 * (31 - i)), 1'b1);
            expect_port(2, 32'(10 * i), 1'b1);
            expect_port(3, 32'h0, 1'b1);
            drain();
            tick();
        end

        // Write to register 0 is dropped, including same-cycle bypass.
        step = "zero_write_same";
        regWrite = 1'b1; rd_addr = 5'd0; write_data = 32'hDEAD_BEEF;
        resv_valid = 1'b1; resv_addr = 5'd0;
        for (int p = 0; p < NR; p++) begin
            set_rd(p, 0);
            expect_port(p, 32'h0, 1'b1);
        end
        drain();
        tick(); idle();
        step = "zero_write_after";
        expect_port(0, 32'h0, 1'b1);
        expect_port(3, 32'h0, 1'b1);
        drain();
        chk_busy(1'b0);

        // Reserve 5, then write it.
        step = "resv5_same";
        set_rd(0, 5); set_rd(1, 6);
        resv_valid = 1'b1; resv_addr = 5'd5;
        expect_port(0, 32'd50, 1'b1);
        drain();
        chk_busy(1'b0);
        tick(); idle();
        step = "resv5_after";
        expect_port(0, 32'd50, 1'b0);
        expect_port(1, 32'd60, 1'b1);
        drain();
        chk_busy(1'b1);
        step = "write5_same";
        regWrite = 1'b1; rd_addr = 5'd5; write_data = 32'h55;
`ifdef REGFILE_BYPASS_EN
        expect_port(0, 32'h55, 1'b1);
`else
        expect_port(0, 32'd50, 1'b0);
`endif
        drain();
        tick(); idle();
        step = "write5_after";
        expect_port(0, 32'h55, 1'b1);
        drain();
        chk_busy(1'b0);

        // Same-cycle reserve and write of reg 7: reservation wins.
        step = "resv_write7";
        regWrite = 1'b1; rd_addr = 5'd7; write_data = 32'h77;
        resv_valid = 1'b1; resv_addr = 5'd7;
        tick(); idle();
        set_rd(0, 7);
        expect_port(0, 32'h77, 1'b0);
        drain();
        chk_busy(1'b1);

        // Flush beats a reservation of 9; simultaneous write of 8 still lands.
        step = "flush";
        flush = 1'b1; resv_valid = 1'b1; resv_addr = 5'd9;
        regWrite = 1'b1; rd_addr = 5'd8; write_data = 32'h88;
        tick(); idle();
        set_rd(0, 7); set_rd(1, 9); set_rd(2, 8);
        expect_port(0, 32'h77, 1'b1);
        expect_port(1, 32'd90, 1'b1);
        expect_port(2, 32'h88, 1'b1);
        drain();
        chk_busy(1'b0);

        // Bypass scenario on reg 3.
        step = "byp_setup";
        regWrite = 1'b1; rd_addr = 5'd3; write_data = 32'h11;
        resv_valid = 1'b1; resv_addr = 5'd3;
        tick(); idle();
        set_rd(0, 3); set_rd(1, 3);
        expect_port(0, 32'h11, 1'b0);
        drain();
        step = "byp_same";
        regWrite = 1'b1; rd_addr = 5'd3; write_data = 32'h33;
`ifdef REGFILE_BYPASS_EN
        expect_port(0, 32'h33, 1'b1);
        expect_port(1, 32'h33, 1'b1);
`else
        expect_port(0, 32'h11, 1'b0);
        expect_port(1, 32'h11, 1'b0);
`endif
        drain();
        tick(); idle();
        step = "byp_after";
        expect_port(0, 32'h33, 1'b1);
        drain();
        chk_busy(1'b0);

        // Mid-sequence reset with pending bits and a write in flight.
        resv_valid = 1'b1; resv_addr = 5'd2; tick();
        resv_addr = 5'd4; tick(); idle();
        step = "pre_reset";
        set_rd(0, 2); set_rd(1, 4);
        expect_port(0, 32'd20, 1'b0);
        expect_port(1, 32'd40, 1'b0);
        drain();
        chk_busy(1'b1);
        rst = 1'b0;
        regWrite = 1'b1; rd_addr = 5'd6; write_data = 32'hABC;
        resv_valid = 1'b1; resv_addr = 5'd10; flush = 1'b1;
        tick(); idle();
        rst = 1'b1;
        step = "mid_reset";
        set_rd(0, 2); set_rd(1, 4); set_rd(2, 6); set_rd(3, 10);
        for (int p = 0; p < NR; p++) expect_port(p, 32'h0, 1'b1);
        drain();
        chk_busy(1'b0);

        // All four ports aliasing one register.
        step = "alias4";
        regWrite = 1'b1; rd_addr = 5'd12; write_data = 32'hCAFE_F00D;
        tick(); idle();
        for (int p = 0; p < NR; p++) begin
            set_rd(p, 12);
            expect_port(p, 32'hCAFE_F00D, 1'b1);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-read-port integer register file for the ID stage, successor to the fixed 2-read/1-write 32x32 file. It adds a configurable read-port count, configurable width and depth, and a per-register pending-write scoreboard so decode can detect RAW hazards. It also has an optional write-to-read bypass. It sits between decode (reads and reservations) and writeback (writes).

## Interface
- WIDTH, 32, data width in bits
- DEPTH, 32, number of architectural registers; power of two, ≥2; AW = log2(DEPTH)
- NUM_READ, 2, number of read ports, 1..4
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset; sampled on clk rising edge
- rs_addr  in  NUM_READ*AW  packed read addresses; port p at [p*AW +: AW]
- rs_data  out  NUM_READ*WIDTH  packed read data, combinational
- rs_ready  out  NUM_READ  port p operand is valid: register not pending, or bypass hit
- rd_addr  in  AW  write address
- write_data  in  WIDTH  write data
- regWrite  in  1  write enable
- resv_valid  in  1  reserve a register as pending-write
- resv_addr  in  AW  register to reserve
- flush  in  1  clear all pending bits; data is untouched
- busy_any  out  1  OR of all pending bits

## Operation
- Register 0 is hardwired zero:
  - Writes and reservations to address 0 are ignored.
  - Reads of 0 return 0 with rs_ready=1.
- Write: on a clk edge with regWrite=1 and rd_addr≠0, regs[rd_addr] <= write_data and pending[rd_addr] <= 0.
- Reserve: on a clk edge with resv_valid=1 and resv_addr≠0, pending[resv_addr] <= 1.
- Write and reserve to the same register in the same cycle: data is written and pending ends at 1 (the new reservation wins).
- Flush: clears all pending bits. Flush has priority over a reserve in the same cycle. A simultaneous write still updates data.
- Reads are combinational: rs_data[p] = regs[rs_addr[p]]; rs_ready[p] = ~pending[rs_addr[p]].
- Any read port may alias any other read port or the write port; there is no port-count restriction.

## Timing
- Reset (rst=0 at a clk edge): all regs <= 0 and all pending <= 0. Reset overrides write, reserve and flush in the same cycle.
- Output values during and after reset:
  - rs_data = 0 for every port
  - rs_ready = all ones
  - busy_any = 0
- Write latency: the data is visible on reads the cycle after the edge; same-cycle visibility only with bypass (see Configuration).
- Reservation latency: rs_ready drops the cycle after the reserving edge.
- busy_any is combinational from the pending register, so it updates one cycle after a reserve or clear.
- Reset asserted mid-sequence (pending bits set, write in flight): all state clears on that edge; the in-flight write is lost.

## Configuration
- REGFILE_BYPASS_EN defined: if regWrite=1, rd_addr≠0 and rd_addr==rs_addr[p], then in the same cycle:
  - rs_data[p] = write_data
  - rs_ready[p] = 1, even if pending (this is the writeback completing the hazard)
- REGFILE_BYPASS_EN undefined: reads return the stored value and stored pending state only. The written value appears the next cycle.

## Structure
- Package regfile_pkg:
  - localparam defaults (WIDTH, DEPTH, NUM_READ)
  - AW as a $clog2 helper
  - a typedef for the register index
  - the ZERO_REG constant
- One sub-module, regfile_scoreboard: holds the DEPTH-bit pending vector, handles reserve/clear/flush/reset priority, and drives busy_any and the per-port pending lookups.
- The data array and read muxes stay in the top module.

## Test plan
- Reset, then write 10*i to regs 1..31 (one per cycle, regWrite=1); read port0=i, port1=31-i.
  - Required: read values are 10*i and 10*(31-i); reg 0 reads 0.
- Write 0xDEAD_BEEF to reg 0, then read reg 0.
  - Required: rs_data=0, rs_ready=1.
- Reserve reg 5 → next cycle rs_ready for addr 5 is 0 and busy_any=1. Write 0x55 to reg 5 → next cycle rs_ready=1, data 0x55, busy_any=0.
- Same cycle: reserve reg 7 and write 0x77 to reg 7.
  - Required next cycle: data 0x77, rs_ready=0.
  - Then flush → rs_ready=1, busy_any=0.
- With REGFILE_BYPASS_EN: regs[3]=0x11 and pending; write 0x33 to reg 3 while reading it.
  - Required: same-cycle rs_data=0x33, rs_ready=1.
  - Without the macro: same-cycle rs_data=0x11, rs_ready=0.
- Regs 2,4 hold nonzero data and pending bits are set; assert rst=0 for one edge.
  - Required: all reads return 0, rs_ready all ones, busy_any=0.
- With NUM_READ=4: four ports read the same register simultaneously.
  - Required: all four return the identical value.
